// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 32-bit binary to 8-digit packed BCD (double dabble), optional BCD_SAT_EN
module bin2bcd_seq #(
  parameter logic [31:0] ERR_CODE = 32'hEEEE_EEEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [32:1] bcd
);

  localparam logic [31:0] MAX_DEC = 32'd99_999_999;
  localparam logic [4:0]  LAST_IT = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shreg;
  logic [31:0] scratch;
  logic [31:0] scratch_adj;
  logic [4:0]  count;
  logic        ovf_pend;
  logic [31:0] result;

  // State register; reset returns to IDLE regardless of start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: one accepting edge, 32 shift edges, one commit edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (count == LAST_IT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every digit of the pre-shift scratch, all digits in parallel.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 8; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Value committed at DONE: the converted digits, or the overflow indication.
  always_comb begin
`ifdef BCD_SAT_EN
    result = ovf_pend ? 32'h9999_9999 : scratch;
`else
    result = ovf_pend ? ERR_CODE : scratch;
`endif
  end

  // Datapath and outputs; bcd/ovf only move at the commit edge so the display never sees partial digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      scratch  <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg    <= bin;
            scratch  <= '0;
            count    <= '0;
            ovf_pend <= (bin > MAX_DEC);
            busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Bit shifted out of scratch[31] is dropped; overflow comes from ovf_pend only.
          scratch <= {scratch_adj[30:0], shreg[31]};
          shreg   <= {shreg[30:0], 1'b0};
          count   <= count + 5'd1;
        end
        S_DONE: begin
          bcd  <= result;
          ovf  <= ovf_pend;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
